// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: serial FSM state encoding and a
// constant clog2 helper for sizing counters.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell built from gate primitives.
//   a, b  : minuend / subtrahend bit
//   bin   : borrow in
//   d     : a ^ b ^ bin
//   bout  : (~a & b) | (~(a ^ b) & bin)
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    wire t_w;
    wire na_w;
    wire nt_w;
    wire g0_w;
    wire g1_w;
    wire d_w;
    wire bout_w;

    xor u_x0 (t_w,  a,    b);
    xor u_x1 (d_w,  t_w,  bin);
    not u_n0 (na_w, a);
    not u_n1 (nt_w, t_w);
    and u_a0 (g0_w, na_w, b);
    and u_a1 (g1_w, nt_w, bin);
    or  u_o0 (bout_w, g0_w, g1_w);

    assign d    = d_w;
    assign bout = bout_w;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = minuend - subtrahend - bin,
// one bit per clock LSB first through a single full-subtractor cell.
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   minuend, subtrahend : WIDTH-bit unsigned operands, bin: borrow in
//   out_valid/out_ready : result handshake (valid held in DONE)
//   diff, bout          : registered result, held until the next DONE
//   busy                : high in RUN or DONE
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int unsigned CW = clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] res_shift;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts the LSB lands at bit 0.
    assign res_shift = (res_q >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d  = ST_RUN;
                    a_d      = minuend;
                    b_d      = subtrahend;
                    borrow_d = bin;
                    cnt_d    = '0;
                    res_d    = '0;
                end
            end
            ST_RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                res_d    = res_shift;
                borrow_d = fs_bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    diff_d  = res_shift;
                    bout_d  = fs_bout;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    // Handshake flags are decoded straight from the state register
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] minuend = '0;
    logic [W-1:0] subtrahend = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;

    logic         rand_rdy = 1'b0;
    logic         rdy_force = 1'b0;
    exp_t         sb_q[$];
    int           n_tests = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .bout       (bout),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pops the scoreboard whenever a transfer will occur on the coming edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got diff=%0h bout=%0b with empty scoreboard", diff, bout);
                end else begin
                    e = sb_q.pop_front();
                    check("result_diff", 32'(diff), 32'(e.diff));
                    check("result_bout", 32'(bout), 32'(e.bout));
                end
            end
        end
    endtask

    task automatic rdy_gen();
        forever begin
            @(negedge clk);
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         input logic [W-1:0] ed, input logic eb);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        minuend    = a;
        subtrahend = b;
        bin        = bi;
        in_valid   = 1'b1;
        for (int k = 0; k < 200; k++) begin
            #3;
            if (in_ready) begin
                @(posedge clk);
                sb_q.push_back('{diff: ed, bout: eb});
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected 1");
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] full;
        int         lat;
        exp_t       dropped;

        fork
            monitor();
            rdy_gen();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_diff",      32'(diff),      32'd0);
        check("rst_bout",      32'(bout),      32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rdy_force = 1'b1;
        @(negedge clk);

        // Directed vectors, first one with latency measurement
        issue(4'd9, 4'd3, 1'b0, 4'h6, 1'b0);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'd4);
        issue(4'd3,  4'd9,  1'b0, 4'hA, 1'b1);
        issue(4'd0,  4'd0,  1'b1, 4'hF, 1'b1);
        issue(4'd15, 4'd15, 1'b0, 4'h0, 1'b0);
        issue(4'd15, 4'd0,  1'b1, 4'hE, 1'b0);
        drain();

        // Backpressure in DONE with spurious operand pulses
        rdy_force = 1'b0;
        issue(4'd12, 4'd5, 1'b0, 4'h7, 1'b0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #3;
            if (out_valid) break;
        end
        check("bp_reach_done", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            minuend    = 4'd1;
            subtrahend = 4'd2;
            bin        = 1'b1;
            #3;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_diff",      32'(diff),      32'h7);
            check("bp_bout",      32'(bout),      32'd0);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_busy",      32'(busy),      32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        rdy_force = 1'b1;
        drain();
        #3;
        check("post_bp_in_ready",  32'(in_ready),  32'd1);
        check("post_bp_out_valid", 32'(out_valid), 32'd0);
        check("post_bp_diff_hold", 32'(diff),      32'h7);

        // Reset during RUN aborts the operation
        issue(4'd10, 4'd3, 1'b0, 4'h7, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        dropped = sb_q.pop_back();
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_diff",      32'(diff),      32'd0);
        check("abort_bout",      32'(bout),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd7, 4'd2, 1'b0, 4'h5, 1'b0);
        drain();

        // Exhaustive back-to-back with random consumer readiness
        rand_rdy = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    full = {1'b0, 4'(a)} - {1'b0, 4'(b)} - 5'(bi);
                    issue(4'(a), 4'(b), 1'(bi), full[3:0], full[4]);
                end
            end
        end
        drain();
        rand_rdy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
